mem8x8_row_reader: RTL and testbench

Read-side sequencer for the 8x8 memory, the counterpart of the write-side 1-to-8 row demux. It takes a start address and a burst length, selects rows through an 8:1 word mux, and streams them out one word per accepted handshake. Row addresses wrap modulo 8. It sits between the memory row array and any consumer, such as a display or serial transmitter.

---
 rtl/mem8x8_row_reader_pkg.sv | 31 +++
 rtl/mem8x8_row_reader_mux.sv | 24 ++
 rtl/mem8x8_row_reader.sv | 84 ++++++++
 tb/tb_mem8x8_row_reader.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem8x8_row_reader_pkg.sv
// ============================================================================
// mem8x8_row_reader_pkg : shared geometry, FSM states and address helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem8x8_row_reader_pkg;

  localparam int MEM_ROWS   = 8;
  localparam int MEM_ADDR_W = 3;
  localparam int MEM_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // addr[0] is the MSB of the row index; the mapping is a bit reversal,
  // so the same function converts in both directions.
  function automatic logic [MEM_ADDR_W-1:0] addr_to_idx(input logic [MEM_ADDR_W-1:0] a);
    return {a[0], a[1], a[2]};
  endfunction

  function automatic logic [MEM_ADDR_W-1:0] idx_to_addr(input logic [MEM_ADDR_W-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem8x8_row_reader_mux.sv
// ============================================================================
// mux8to1word : combinational 8:1 word selector, write-demux address order
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux8to1word
  import mem8x8_row_reader_pkg::*;
#(
  parameter int WIDTH = MEM_WIDTH
) (
  input  logic [MEM_ROWS*WIDTH-1:0] rows,
  input  logic [MEM_ADDR_W-1:0]     sel,
  output logic [WIDTH-1:0]          word
);

  logic [MEM_ADDR_W-1:0] idx;

  assign idx  = addr_to_idx(sel);
  assign word = rows[idx*WIDTH +: WIDTH];

endmodule

`default_nettype wire

// File: rtl/mem8x8_row_reader.sv
// ============================================================================
// mem8x8_row_reader : burst read sequencer streaming rows with valid/ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem8x8_row_reader
  import mem8x8_row_reader_pkg::*;
#(
  parameter int WIDTH = MEM_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [MEM_ROWS*WIDTH-1:0] mem_rows,
  input  logic                    start,
  input  logic [MEM_ADDR_W-1:0]   start_addr,
  input  logic [MEM_ADDR_W-1:0]   burst_len,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    rd_valid,
  output logic [WIDTH-1:0]        rd_data,
  output logic [MEM_ADDR_W-1:0]   rd_addr,
  output logic                    done
);

  state_t                state, state_nxt;
  logic [MEM_ADDR_W:0]   remaining;
  logic [MEM_ADDR_W-1:0] next_addr;
  logic [MEM_ADDR_W-1:0] sel;
  logic [WIDTH-1:0]      sel_word;
  logic                  handshake;
  logic                  take_start;
  logic                  load_word;

  assign handshake  = (state == STREAM) && out_ready;
  assign take_start = (state == IDLE) && start;
  assign load_word  = take_start || (handshake && (remaining > 4'd1));

  // Increment happens in index space, then maps back to address order.
  assign next_addr = idx_to_addr(addr_to_idx(rd_addr) + 3'd1);
  assign sel       = (state == IDLE) ? start_addr : next_addr;

  mux8to1word #(.WIDTH(WIDTH)) u_mux (
    .rows (mem_rows),
    .sel  (sel),
    .word (sel_word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (out_ready && (remaining == 4'd1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else begin
      state <= state_nxt;
      if (take_start)
        remaining <= (burst_len == 3'd0) ? 4'd8 : {1'b0, burst_len};
      else if (handshake)
        remaining <= remaining - 4'd1;
      if (load_word) begin
        rd_addr <= sel;
        rd_data <= sel_word;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign rd_valid = (state == STREAM);
  assign done     = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_mem8x8_row_reader.sv
// ============================================================================
// tb_mem8x8_row_reader : randomized self-checking bench with burst-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem8x8_row_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] mem_rows;
  logic        start;
  logic [2:0]  start_addr;
  logic [2:0]  burst_len;
  logic        out_ready;
  logic        busy, rd_valid, done;
  logic [7:0]  rd_data;
  logic [2:0]  rd_addr;

  logic [7:0]  mem [8];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    mem_rows = '0;
    for (int i = 0; i < 8; i++) mem_rows[i*8 +: 8] = mem[i];
  end

  mem8x8_row_reader #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_rows   (mem_rows),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .out_ready  (out_ready),
    .busy       (busy),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_addr    (rd_addr),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Row index from an address: 4*a[0] + 2*a[1] + a[2].
  function automatic int addr_index(input logic [2:0] a);
    return 4*a[0] + 2*a[1] + a[2];
  endfunction

  // Address whose decoded index equals idx, found by search.
  function automatic logic [2:0] index_addr(input int idx);
    logic [2:0] a;
    for (int c = 0; c < 8; c++) begin
      a = c[2:0];
      if (addr_index(a) == idx) return a;
    end
    return 3'b000;
  endfunction

  // One full burst. first_stall < 0 means random stalls on every word.
  // abort_after >= 0 asserts reset after that many words have been accepted.
  task automatic run_burst(input logic [2:0] addr, input logic [2:0] len,
                           input int first_stall, input bit poke_start,
                           input bit poke_done, input int abort_after);
    int         n, idx0, stalls;
    logic [7:0] snap;
    n    = (len == 3'd0) ? 8 : int'(len);
    idx0 = addr_index(addr);
    @(negedge clk);
    check("idle_before", {busy, rd_valid, done}, 3'b000);
    snap       = mem[idx0];
    start      = 1'b1;
    start_addr = addr;
    burst_len  = len;
    out_ready  = 1'b0;
    for (int k = 0; k < n; k++) begin
      stalls = (first_stall >= 0) ? ((k == 0) ? first_stall : 0) : int'($urandom_range(0, 2));
      for (int s = 0; s <= stalls; s++) begin
        @(negedge clk);
        start      = (poke_start && k == 2) ? 1'b1 : 1'b0;
        start_addr = $urandom;
        burst_len  = $urandom;
        check("valid",    rd_valid, 1'b1);
        check("busy",     busy,     1'b1);
        check("no_done",  done,     1'b0);
        check("rd_addr",  rd_addr,  index_addr((idx0 + k) % 8));
        check("rd_data",  rd_data,  snap);
        if (k == abort_after) begin
          rst_n = 1'b0;
          out_ready = $urandom;
          @(negedge clk);
          check("rst_state", {busy, rd_valid, done}, 3'b000);
          check("rst_data",  {rd_data, 5'b0, rd_addr}, 16'h0000);
          rst_n = 1'b1;
          start = 1'b0;
          return;
        end
        if (s < stalls) begin
          out_ready = 1'b0;
          for (int r = 0; r < 8; r++) mem[r] = $urandom;
        end else begin
          out_ready = 1'b1;
          if (k + 1 < n) snap = mem[(idx0 + k + 1) % 8];
        end
      end
    end
    @(negedge clk);
    start     = poke_done;
    out_ready = $urandom;
    check("done_pulse", {busy, rd_valid, done}, 3'b101);
    @(negedge clk);
    start = 1'b0;
    check("back_idle", {busy, rd_valid, done}, 3'b000);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0; out_ready = 1'b0;
    for (int r = 0; r < 8; r++) mem[r] = 8'hA0 + 8'(r);
    repeat (2) @(negedge clk);
    check("reset_state", {busy, rd_valid, done}, 3'b000);
    check("reset_data",  {rd_data, 5'b0, rd_addr}, 16'h0000);
    rst_n = 1'b1;

    run_burst(3'b001, 3'd1, 0, 1'b0, 1'b0, -1);   // decode order, index 4
    run_burst(3'b011, 3'd4, 0, 1'b0, 1'b0, -1);   // index 6 wrapping to 1
    run_burst(3'b100, 3'd2, 3, 1'b0, 1'b0, -1);   // backpressure with row churn
    run_burst(3'b110, 3'd0, 0, 1'b1, 1'b1, -1);   // full burst, starts ignored
    run_burst(3'b010, 3'd5, 0, 1'b0, 1'b0, 1);    // reset mid-stream
    run_burst(3'b101, 3'd3, 0, 1'b0, 1'b0, -1);   // normal after reset

    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 8; r++) mem[r] = $urandom;
      run_burst(3'($urandom), 3'($urandom), -1, 1'($urandom), 1'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
